regfile_writeback: RTL and testbench

//  Write-back pipeline stage directly upstream of the 32x32 file register.
//  - Registers MEM-stage results and selects ALU result or load data.
//  - Drives the file register write ports: we, reg_dst, write0_addr, write1_addr, write_data.
//  - Commits each instruction exactly once, even under stall.
//  - Bypasses the in-flight write to decode-stage reads and counts committed writes.

---
 rtl/regfile_writeback_if.sv | 46 ++++
 rtl/regfile_writeback.sv | 89 ++++++++
 tb/tb_regfile_writeback.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_writeback_if.sv
// Signal bundle between the MEM stage, the decode stage, the register file and
// the write-back stage. The write-back stage connects through the slave modport.
interface regfile_writeback_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 16
);
    logic              stall;
    logic              flush;
    logic              in_valid;
    logic              in_reg_write;
    logic              in_mem_to_reg;
    logic              in_reg_dst;
    logic [ADDR_W-1:0] in_rt_addr;
    logic [ADDR_W-1:0] in_rd_addr;
    logic [DATA_W-1:0] in_alu_result;
    logic [DATA_W-1:0] in_mem_data;
    logic [ADDR_W-1:0] id_rs_addr;
    logic [ADDR_W-1:0] id_rt_addr;
    logic [DATA_W-1:0] rf_read0_data;
    logic [DATA_W-1:0] rf_read1_data;
    logic              we;
    logic              reg_dst;
    logic [ADDR_W-1:0] write0_addr;
    logic [ADDR_W-1:0] write1_addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] fwd_read0_data;
    logic [DATA_W-1:0] fwd_read1_data;
    logic [CNT_W-1:0]  wb_count;

    modport master (
        output stall, flush, in_valid, in_reg_write, in_mem_to_reg, in_reg_dst,
               in_rt_addr, in_rd_addr, in_alu_result, in_mem_data,
               id_rs_addr, id_rt_addr, rf_read0_data, rf_read1_data,
        input  we, reg_dst, write0_addr, write1_addr, write_data,
               fwd_read0_data, fwd_read1_data, wb_count
    );

    modport slave (
        input  stall, flush, in_valid, in_reg_write, in_mem_to_reg, in_reg_dst,
               in_rt_addr, in_rd_addr, in_alu_result, in_mem_data,
               id_rs_addr, id_rt_addr, rf_read0_data, rf_read1_data,
        output we, reg_dst, write0_addr, write1_addr, write_data,
               fwd_read0_data, fwd_read1_data, wb_count
    );
endinterface

// File: rtl/regfile_writeback.sv
// Write-back stage: registers MEM results, drives the register file write port
// exactly once per instruction, bypasses the in-flight write and counts commits.
module regfile_writeback #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 16
) (
    input logic               clk,
    input logic               rst_all,
    regfile_writeback_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        HELD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              we;
    logic              wr_ok;
    logic [ADDR_W-1:0] dest;
    logic              reg_dst_q;
    logic [ADDR_W-1:0] write0_addr_q;
    logic [ADDR_W-1:0] write1_addr_q;
    logic [DATA_W-1:0] write_data_q;
    logic [CNT_W-1:0]  wb_count_q;
    logic [ADDR_W-1:0] sel_addr;

    assign dest  = bus.in_reg_dst ? bus.in_rd_addr : bus.in_rt_addr;
    assign wr_ok = bus.in_valid & bus.in_reg_write & (dest != '0);

    always_ff @(posedge clk) begin
        if (rst_all) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // A stalled WRITE has already committed, so it parks in HELD with we low.
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else if (bus.stall) begin
            state_d = (state_q == IDLE) ? IDLE : HELD;
        end else begin
            state_d = wr_ok ? WRITE : IDLE;
        end
    end

    always_comb begin
        we = (state_q == WRITE);
    end

    always_ff @(posedge clk) begin
        if (rst_all) begin
            reg_dst_q     <= 1'b0;
            write0_addr_q <= '0;
            write1_addr_q <= '0;
            write_data_q  <= '0;
        end else if (!bus.flush && !bus.stall) begin
            reg_dst_q     <= bus.in_reg_dst;
            write0_addr_q <= bus.in_rt_addr;
            write1_addr_q <= bus.in_rd_addr;
            write_data_q  <= bus.in_mem_to_reg ? bus.in_mem_data : bus.in_alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_all)  wb_count_q <= '0;
        else if (we)  wb_count_q <= wb_count_q + CNT_W'(1);
    end

    assign sel_addr = reg_dst_q ? write1_addr_q : write0_addr_q;

    always_comb begin
        bus.fwd_read0_data = bus.rf_read0_data;
        bus.fwd_read1_data = bus.rf_read1_data;
        if (we && (sel_addr == bus.id_rs_addr) && (bus.id_rs_addr != '0))
            bus.fwd_read0_data = write_data_q;
        if (we && (sel_addr == bus.id_rt_addr) && (bus.id_rt_addr != '0))
            bus.fwd_read1_data = write_data_q;
    end

    assign bus.we          = we;
    assign bus.reg_dst     = reg_dst_q;
    assign bus.write0_addr = write0_addr_q;
    assign bus.write1_addr = write1_addr_q;
    assign bus.write_data  = write_data_q;
    assign bus.wb_count    = wb_count_q;
endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios plus random
// traffic checked against an instruction-level model with its own register file.
module tb_regfile_writeback;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned CNT_W  = 16;

    logic clk = 1'b0;
    logic rst_all = 1'b0;
    always #5 clk = ~clk;

    regfile_writeback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    regfile_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_all (rst_all),
        .bus     (bus)
    );

    logic [DATA_W-1:0] rf [32];
    assign bus.rf_read0_data = rf[bus.id_rs_addr];
    assign bus.rf_read1_data = rf[bus.id_rt_addr];

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Model: one pending write (or none), the last loaded instruction fields and a count.
    logic              m_we;
    logic [ADDR_W-1:0] m_dst;
    logic [DATA_W-1:0] m_data;
    logic              m_regdst;
    logic [ADDR_W-1:0] m_rt, m_rd;
    logic              m_known;
    int unsigned       m_cnt;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_fwd(input logic [ADDR_W-1:0] id);
        if (m_we && id != 0 && id == m_dst) return m_data;
        return rf[id];
    endfunction

    task automatic model_edge();
        logic [ADDR_W-1:0] d;
        if (m_we) rf[m_dst] = m_data;
        if (rst_all) begin
            m_we = 0; m_cnt = 0; m_regdst = 0; m_rt = 0; m_rd = 0; m_data = 0; m_known = 1;
        end else begin
            if (m_we) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            if (bus.flush) begin
                m_we = 0; m_known = 0;
            end else if (bus.stall) begin
                m_we = 0;
            end else begin
                d        = bus.in_reg_dst ? bus.in_rd_addr : bus.in_rt_addr;
                m_regdst = bus.in_reg_dst;
                m_rt     = bus.in_rt_addr;
                m_rd     = bus.in_rd_addr;
                m_data   = bus.in_mem_to_reg ? bus.in_mem_data : bus.in_alu_result;
                m_dst    = d;
                m_we     = bus.in_valid & bus.in_reg_write & (d != 0);
                m_known  = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("we", DATA_W'(bus.we), DATA_W'(m_we));
        chk("wb_count", DATA_W'(bus.wb_count), DATA_W'(m_cnt));
        chk("fwd0", bus.fwd_read0_data, exp_fwd(bus.id_rs_addr));
        chk("fwd1", bus.fwd_read1_data, exp_fwd(bus.id_rt_addr));
        if (m_known) begin
            chk("reg_dst", DATA_W'(bus.reg_dst), DATA_W'(m_regdst));
            chk("write0_addr", DATA_W'(bus.write0_addr), DATA_W'(m_rt));
            chk("write1_addr", DATA_W'(bus.write1_addr), DATA_W'(m_rd));
            chk("write_data", bus.write_data, m_data);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #2;
        check_all();
    endtask

    task automatic set_instr(input logic v, input logic rw, input logic m2r, input logic rdst,
                             input logic [ADDR_W-1:0] rt, input logic [ADDR_W-1:0] rd,
                             input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] mem);
        bus.in_valid = v; bus.in_reg_write = rw; bus.in_mem_to_reg = m2r; bus.in_reg_dst = rdst;
        bus.in_rt_addr = rt; bus.in_rd_addr = rd; bus.in_alu_result = alu; bus.in_mem_data = mem;
    endtask

    initial begin
        int unsigned c0;
        for (int i = 0; i < 32; i++) rf[i] = 0;
        m_we = 0; m_dst = 0; m_data = 0; m_regdst = 0; m_rt = 0; m_rd = 0; m_known = 0; m_cnt = 0;
        bus.stall = 0; bus.flush = 0; bus.id_rs_addr = 0; bus.id_rt_addr = 0;

        // 1: reset with junk inputs
        set_instr(1, 1, 1, 1, 5'd7, 5'd9, 32'hDEADBEEF, 32'hCAFEF00D);
        rst_all = 1;
        step();
        chk("reset_wb_count_zero", DATA_W'(bus.wb_count), '0);
        rst_all = 0;

        // 2: simple ALU write to r1, then read it back
        set_instr(1, 1, 0, 0, 5'd1, 5'd0, 32'h5ADFACED, 32'h0);
        bus.id_rs_addr = 5'd1;
        step();
        chk("t2_we", DATA_W'(bus.we), 1);
        chk("t2_data", bus.write_data, 32'h5ADFACED);
        set_instr(0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0);
        step();
        chk("t2_r1", bus.fwd_read0_data, 32'h5ADFACED);
        chk("t2_cnt", DATA_W'(bus.wb_count), 1);

        // 3: load to r15, stalled for 3 cycles: exactly one commit
        set_instr(1, 1, 1, 1, 5'd3, 5'd15, 32'h11111111, 32'hEA770A57);
        step();
        c0 = m_cnt;
        bus.stall = 1;
        for (int i = 0; i < 3; i++) step();
        chk("t3_we_held", DATA_W'(bus.we), 0);
        chk("t3_cnt", DATA_W'(bus.wb_count), DATA_W'(c0 + 1));
        bus.stall = 0;
        set_instr(0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0);
        step();

        // 4: bypass of in-flight r21 on read1; r0 never bypassed
        set_instr(1, 1, 0, 1, 5'd2, 5'd21, 32'hEA770A57, 32'h0);
        bus.id_rt_addr = 5'd21;
        step();
        chk("t4_fwd1_bypass", bus.fwd_read1_data, 32'hEA770A57);
        bus.id_rt_addr = 5'd0;
        #1 chk("t4_fwd1_r0", bus.fwd_read1_data, rf[0]);
        set_instr(0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0);
        step();

        // 5: dest 0 never writes; flush + stall together squash
        set_instr(1, 1, 0, 0, 5'd0, 5'd4, 32'h12345678, 32'h0);
        c0 = m_cnt;
        step();
        step();
        chk("t5_dest0_we", DATA_W'(bus.we), 0);
        chk("t5_dest0_cnt", DATA_W'(bus.wb_count), DATA_W'(c0));
        set_instr(1, 1, 0, 1, 5'd0, 5'd6, 32'h0BADC0DE, 32'h0);
        step();
        bus.flush = 1; bus.stall = 1;
        step();
        chk("t5_flush_we", DATA_W'(bus.we), 0);
        bus.flush = 0; bus.stall = 0;
        set_instr(0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0);
        step();

        // reset in the middle of a write still commits it to the file
        set_instr(1, 1, 0, 0, 5'd9, 5'd0, 32'h99990000, 32'h0);
        step();
        rst_all = 1;
        step();
        rst_all = 0;
        bus.id_rs_addr = 5'd9;
        #1 chk("rst_mid_commit", bus.fwd_read0_data, 32'h99990000);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            set_instr(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom),
                      1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      $urandom, $urandom);
            bus.stall = ($urandom_range(0, 4) == 0);
            bus.flush = ($urandom_range(0, 9) == 0);
            rst_all   = ($urandom_range(0, 49) == 0);
            bus.id_rs_addr = 5'($urandom_range(0, 7));
            bus.id_rt_addr = 5'($urandom_range(0, 7));
            step();
        end
        rst_all = 0; bus.stall = 0; bus.flush = 0;

        // 6: counter wrap
        set_instr(1, 1, 0, 0, 5'd5, 5'd0, 32'h00000005, 32'h0);
        while (m_cnt != (1 << CNT_W) - 2) step();
        step();
        chk("t6_cnt_max", DATA_W'(bus.wb_count), DATA_W'((1 << CNT_W) - 1));
        step();
        chk("t6_cnt_wrap", DATA_W'(bus.wb_count), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
